// File: rtl/dsc_mul_seq.sv
// Operand sequencer and result capture for the dsc_mul stochastic multiplier core.
// Takes operand tuples over valid/ready, runs the core until ov or timeout, and returns the result over valid/ready.
module dsc_mul_seq #(
    parameter int WIDTH      = 8,
    parameter int CNT_WIDTH  = 32,
    parameter int MAX_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [WIDTH-1:0]       in_c,
    input  logic [WIDTH-1:0]       in_d,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*WIDTH-1:0]     out_z,
    output logic [CNT_WIDTH-1:0]   out_cycles,
    output logic                   out_timeout,
    output logic                   busy,
    output logic                   mul_rst,
    output logic                   mul_en,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    output logic [WIDTH-1:0]       mul_c,
    output logic [WIDTH-1:0]       mul_d,
    input  logic [4*WIDTH-1:0]     mul_z,
    input  logic                   mul_ov
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(MAX_CYCLES);
    localparam logic                 TIMEOUT_EN  = (MAX_CYCLES != 0);

    state_t                 state_r;
    logic [CNT_WIDTH-1:0]   count_r;
    logic [WIDTH-1:0]       mul_a_r;
    logic [WIDTH-1:0]       mul_b_r;
    logic [WIDTH-1:0]       mul_c_r;
    logic [WIDTH-1:0]       mul_d_r;
    logic [4*WIDTH-1:0]     out_z_r;
    logic [CNT_WIDTH-1:0]   out_cycles_r;
    logic                   out_timeout_r;

    logic [CNT_WIDTH-1:0]   cnt_inc_s;
    logic                   any_zero_s;
    logic                   timeout_hit_s;
    logic                   in_ready_s;

    // Next-count, zero-operand and timeout decodes used by the FSM.
    always_comb begin
        cnt_inc_s     = (count_r == CNT_MAX) ? count_r : (count_r + CNT_ONE);
        any_zero_s    = (in_a == {WIDTH{1'b0}}) | (in_b == {WIDTH{1'b0}}) |
                        (in_c == {WIDTH{1'b0}}) | (in_d == {WIDTH{1'b0}});
        timeout_hit_s = TIMEOUT_EN && (cnt_inc_s == TIMEOUT_CNT);
        in_ready_s    = (state_r == ST_IDLE) && !rst;
    end

    // Sequencer FSM with operand, counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            count_r       <= {CNT_WIDTH{1'b0}};
            mul_a_r       <= {WIDTH{1'b0}};
            mul_b_r       <= {WIDTH{1'b0}};
            mul_c_r       <= {WIDTH{1'b0}};
            mul_d_r       <= {WIDTH{1'b0}};
            out_z_r       <= {(4*WIDTH){1'b0}};
            out_cycles_r  <= {CNT_WIDTH{1'b0}};
            out_timeout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_s) begin
                        mul_a_r <= in_a;
                        mul_b_r <= in_b;
                        mul_c_r <= in_c;
                        mul_d_r <= in_d;
                        count_r <= {CNT_WIDTH{1'b0}};
                        // A zero operand forces a zero product; skip the core entirely.
                        if (any_zero_s) begin
                            out_z_r       <= {(4*WIDTH){1'b0}};
                            out_cycles_r  <= {CNT_WIDTH{1'b0}};
                            out_timeout_r <= 1'b0;
                            state_r       <= ST_DONE;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (mul_ov) begin
                        out_z_r       <= mul_z;
                        out_cycles_r  <= cnt_inc_s;
                        out_timeout_r <= 1'b0;
                        state_r       <= ST_DONE;
                    end else if (timeout_hit_s) begin
                        out_z_r       <= mul_z;
                        out_cycles_r  <= TIMEOUT_CNT;
                        out_timeout_r <= 1'b1;
                        state_r       <= ST_DONE;
                    end else begin
                        count_r <= cnt_inc_s;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = (state_r == ST_DONE);
    assign busy        = (state_r == ST_RUN);
    assign mul_en      = (state_r == ST_RUN);
    // Core stays in reset outside RUN so every run starts from a clean state.
    assign mul_rst     = rst | (state_r != ST_RUN);
    assign mul_a       = mul_a_r;
    assign mul_b       = mul_b_r;
    assign mul_c       = mul_c_r;
    assign mul_d       = mul_d_r;
    assign out_z       = out_z_r;
    assign out_cycles  = out_cycles_r;
    assign out_timeout = out_timeout_r;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Bench for dsc_mul_seq: behavioural core stub (ov after K enabled cycles, z=a*b*c*d)
// and a transaction-level model of the expected result, cycle count and latency.
module tb_dsc_mul_seq;

    localparam int MAXC = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a, in_b, in_c, in_d;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic [31:0] out_cycles;
    logic        out_timeout;
    logic        busy;
    logic        mul_rst;
    logic        mul_en;
    logic [7:0]  mul_a, mul_b, mul_c, mul_d;
    logic [31:0] mul_z;
    logic        mul_ov;

    int errors = 0;
    int checks = 0;
    int stub_k = 0;
    int stub_cnt = 0;

    dsc_mul_seq #(.WIDTH(8), .CNT_WIDTH(32), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_cycles(out_cycles), .out_timeout(out_timeout),
        .busy(busy), .mul_rst(mul_rst), .mul_en(mul_en),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_d(mul_d),
        .mul_z(mul_z), .mul_ov(mul_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stub: counts enabled cycles since its last reset; stub_k==0 never completes.
    always @(posedge clk) begin
        if (mul_rst) stub_cnt <= 0;
        else if (mul_en) stub_cnt <= stub_cnt + 1;
    end
    assign mul_ov = mul_en && (stub_k != 0) && (stub_cnt + 1 == stub_k);
    assign mul_z  = 32'(mul_a) * 32'(mul_b) * 32'(mul_c) * 32'(mul_d);

    typedef struct packed {
        logic [31:0] z;
        logic [31:0] cycles;
        logic        to;
        logic [31:0] runlen;
    } exp_t;

    function automatic exp_t model(input logic [7:0] a, b, c, d, input int k);
        exp_t e;
        if (a == 8'd0 || b == 8'd0 || c == 8'd0 || d == 8'd0) begin
            e.z = 32'd0; e.cycles = 32'd0; e.to = 1'b0; e.runlen = 32'd0;
        end else begin
            e.z = 32'(a) * 32'(b) * 32'(c) * 32'(d);
            if (k >= 1 && k <= MAXC) begin
                e.cycles = 32'(k); e.to = 1'b0;
            end else begin
                e.cycles = 32'(MAXC); e.to = 1'b1;
            end
            e.runlen = e.cycles;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_txn(input logic [7:0] a, b, c, d, input int k);
        int w;
        stub_k = k;
        in_a = a; in_b = b; in_c = c; in_d = d;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            step();
            w++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait: in_ready=%0b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    // Called in the cycle right after the accepting edge.
    task automatic collect(input logic [7:0] a, b, c, d, input int k, input string nm, input bit drain);
        exp_t e;
        int lat, run;
        bit en_seen;
        e = model(a, b, c, d, k);
        lat = 1; run = 0; en_seen = 1'b0;
        checks++;
        if ({mul_a, mul_b, mul_c, mul_d} !== {a, b, c, d}) begin
            errors++;
            $display("FAIL %s operands: got %h required %h", nm, {mul_a, mul_b, mul_c, mul_d}, {a, b, c, d});
        end
        while (!out_valid && lat < 200) begin
            if (busy) run++;
            if (mul_en) en_seen = 1'b1;
            step();
            lat++;
        end
        checks++;
        if (lat !== int'(e.runlen) + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", nm, lat, e.runlen + 1);
        end
        checks++;
        if (run !== int'(e.runlen)) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d required %0d", nm, run, e.runlen);
        end
        if (e.runlen == 0) begin
            checks++;
            if (en_seen !== 1'b0) begin
                errors++;
                $display("FAIL %s mul_en_rose: got %0b required 0", nm, en_seen);
            end
        end
        checks++;
        if ({out_z, out_cycles, out_timeout} !== {e.z, e.cycles, e.to}) begin
            errors++;
            $display("FAIL %s result: got z=%0d cyc=%0d to=%0b required z=%0d cyc=%0d to=%0b",
                     nm, out_z, out_cycles, out_timeout, e.z, e.cycles, e.to);
        end
        checks++;
        if ({out_valid, mul_rst, mul_en, busy, in_ready} !== 5'b11000) begin
            errors++;
            $display("FAIL %s done_flags: got %b required 11000", nm, {out_valid, mul_rst, mul_en, busy, in_ready});
        end
        if (drain) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            checks++;
            if ({out_valid, in_ready} !== 2'b01 || out_z !== e.z || out_cycles !== e.cycles) begin
                errors++;
                $display("FAIL %s drain: got valid=%0b ready=%0b z=%0d cyc=%0d required 0 1 %0d %0d",
                         nm, out_valid, in_ready, out_z, out_cycles, e.z, e.cycles);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        in_a = 8'd3; in_b = 8'd4; in_c = 8'd5; in_d = 8'd6;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({in_ready, out_valid, busy, mul_rst, mul_en, out_timeout} !== 6'b000100 ||
                out_z !== 32'd0 || out_cycles !== 32'd0 || {mul_a, mul_b, mul_c, mul_d} !== 32'd0) begin
                errors++;
                $display("FAIL reset_state: got rdy=%0b v=%0b busy=%0b mrst=%0b en=%0b to=%0b z=%0d cyc=%0d ops=%h required 0 0 0 1 0 0 0 0 0",
                         in_ready, out_valid, busy, mul_rst, mul_en, out_timeout, out_z, out_cycles,
                         {mul_a, mul_b, mul_c, mul_d});
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        step();
        checks++;
        if ({in_ready, out_valid, mul_rst} !== 3'b101) begin
            errors++;
            $display("FAIL reset_release: got %b required 101", {in_ready, out_valid, mul_rst});
        end
    endtask

    task automatic test_basic();
        accept_txn(8'd15, 8'd15, 8'd15, 8'd15, 5);
        collect(8'd15, 8'd15, 8'd15, 8'd15, 5, "basic", 1'b1);
        checks++;
        if (out_z !== 32'd50625) begin
            errors++;
            $display("FAIL basic_const: got %0d required 50625", out_z);
        end
    endtask

    task automatic test_zero();
        accept_txn(8'd0, 8'd200, 8'd7, 8'd9, 4);
        collect(8'd0, 8'd200, 8'd7, 8'd9, 4, "zero", 1'b1);
    endtask

    task automatic test_backpressure();
        logic [31:0] z0, c0;
        accept_txn(8'd11, 8'd12, 8'd13, 8'd14, 3);
        collect(8'd11, 8'd12, 8'd13, 8'd14, 3, "bp_first", 1'b0);
        z0 = out_z; c0 = out_cycles;
        in_valid = 1'b1; in_a = 8'd2; in_b = 8'd3; in_c = 8'd5; in_d = 8'd7;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({out_valid, in_ready, busy} !== 3'b100 || out_z !== z0 || out_cycles !== c0 ||
                {mul_a, mul_b, mul_c, mul_d} !== {8'd11, 8'd12, 8'd13, 8'd14}) begin
                errors++;
                $display("FAIL bp_hold: got v/r/b=%b z=%0d cyc=%0d ops=%h required 100 z=%0d cyc=%0d ops=0b0c0d0e",
                         {out_valid, in_ready, busy}, out_z, out_cycles, {mul_a, mul_b, mul_c, mul_d}, z0, c0);
            end
        end
        stub_k = 6;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: got %b required 01", {out_valid, in_ready});
        end
        step();
        in_valid = 1'b0;
        collect(8'd2, 8'd3, 8'd5, 8'd7, 6, "bp_second", 1'b1);
    endtask

    task automatic test_timeout();
        logic [7:0] a, b, c, d;
        a = 8'($urandom_range(1, 255)); b = 8'($urandom_range(1, 255));
        c = 8'($urandom_range(1, 255)); d = 8'($urandom_range(1, 255));
        accept_txn(a, b, c, d, 0);
        collect(a, b, c, d, 0, "timeout_A", 1'b1);
        accept_txn(d, c, b, a, 16);
        collect(d, c, b, a, 16, "timeout_B", 1'b1);
    endtask

    task automatic test_mid_reset();
        accept_txn(8'd9, 8'd8, 8'd7, 8'd6, 10);
        step();
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_run3: busy=%0b required 1", busy);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({mul_en, mul_rst, busy, out_valid} !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_abort: got %b required 0100", {mul_en, mul_rst, busy, out_valid});
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL midrst_idle: got %b required 01", {out_valid, in_ready});
            end
        end
        accept_txn(8'd4, 8'd5, 8'd6, 8'd7, 10);
        collect(8'd4, 8'd5, 8'd6, 8'd7, 10, "midrst_next", 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] op [4];
        int k;
        for (int t = 0; t < 12; t++) begin
            for (int j = 0; j < 4; j++) begin
                op[j] = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            end
            k = $urandom_range(0, 18);
            accept_txn(op[0], op[1], op[2], op[3], k);
            collect(op[0], op[1], op[2], op[3], k, "random", 1'b1);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = 8'd0; in_b = 8'd0; in_c = 8'd0; in_d = 8'd0;
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dsc_mul_seq.md
# dsc_mul_seq

Operand sequencer and result capture for the 4-input deterministic stochastic multiplier core (`dsc_mul`).
- Upstream, it accepts one 4-operand tuple per transaction over a valid/ready handshake and drives the core's `rst`/`en`/`a`..`d`.
- Downstream, it waits for the core's `ov` completion flag, then captures `z` and the number of run cycles.
- It presents the result on a valid/ready output port.
- It replaces the open-loop reset/enable/wait sequencing that benches currently do by hand, so the core can sit in a streaming datapath.

## Interface
Parameters:
- `WIDTH`, 8, operand width; result width is 4*WIDTH.
- `CNT_WIDTH`, 32, width of the run-cycle counter.
- `MAX_CYCLES`, 0, run-cycle timeout. 0 disables the timeout.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: synchronous active-high reset.
- `in_valid` in 1: operand tuple valid.
- `in_ready` out 1: sequencer can accept a tuple.
- `in_a`, `in_b`, `in_c`, `in_d` in WIDTH each: operands.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_z` out 4*WIDTH: captured product.
- `out_cycles` out CNT_WIDTH: RUN cycles used.
- `out_timeout` out 1: result was produced by timeout, not by `ov`.
- `busy` out 1: core is running.
- `mul_rst` out 1: drives core `rst`.
- `mul_en` out 1: drives core `en`.
- `mul_a`, `mul_b`, `mul_c`, `mul_d` out WIDTH each: drive core operands.
- `mul_z` in 4*WIDTH: core result.
- `mul_ov` in 1: core completion flag.

## Operation
- FSM states: IDLE, RUN, DONE.
- Combinational decodes:
  - `in_ready` = (state==IDLE) & !rst
  - `busy` = (state==RUN)
  - `mul_en` = (state==RUN)
  - `mul_rst` = rst | (state!=RUN). The core is held in reset in IDLE and DONE, so it is always clean on entering RUN.
- IDLE:
  - On accept (`in_valid & in_ready`), latch `in_a`..`in_d` into the `mul_a`..`mul_d` registers and clear the counter.
  - If any operand is 0, go directly to DONE with `out_z`=0, `out_cycles`=0, `out_timeout`=0. The core is never enabled.
  - Otherwise go to RUN.
- RUN: each cycle, evaluate the checks in priority order.
  1. If `mul_ov`=1: `out_z`<=`mul_z`, `out_cycles`<=count+1, `out_timeout`<=0, go to DONE.
  2. Else if MAX_CYCLES!=0 and count+1==MAX_CYCLES: `out_z`<=`mul_z`, `out_cycles`<=MAX_CYCLES, `out_timeout`<=1, go to DONE.
  3. Else count<=count+1, saturating at all-ones.
- DONE:
  - `out_valid`=1. `out_z`, `out_cycles` and `out_timeout` are held stable until `out_valid & out_ready`; then go to IDLE.
  - `in_valid` is ignored while in RUN and DONE.
- Operand registers and the `out_*` data fields hold their last values in IDLE. Only `out_valid` drops.
- `mul_ov` is ignored outside RUN.
- Simultaneous `mul_ov` and timeout in the same cycle: `ov` wins, `out_timeout`=0.

## Timing
- Reset values:
  - State IDLE, `in_ready`=0 while `rst`=1.
  - `out_valid`=0, `out_z`=0, `out_cycles`=0, `out_timeout`=0, `busy`=0.
  - `mul_rst`=1, `mul_en`=0, `mul_a`..`mul_d`=0, counter=0.
- `rst` takes effect at the next edge from any state. A reset during RUN aborts the operation with no result emitted and no `out_valid` pulse.
- Normal operation: accept at edge N; RUN begins in cycle N+1.
  - If the core asserts `ov` in the k-th RUN cycle, `out_valid` rises in cycle N+k+1 with `out_cycles`=k.
  - `mul_rst` is asserted again in that same cycle.
- Zero-operand shortcut: accept at edge N, `out_valid`=1 in cycle N+1.
- Result handshake at edge M: `in_ready`=1 in cycle M+1. Minimum spacing between accepts is k+2 cycles.
- Backpressure: with `out_ready`=0 in DONE, all outputs are held indefinitely.

## Test plan
Benches use a behavioural core stub that asserts `mul_ov` after a programmable K cycles of `en`, with `mul_z`=a*b*c*d.
1. Reset:
   - Stimulus: `rst`=1 for 3 cycles with `in_valid`=1.
   - Required: all outputs at their reset values, `mul_rst`=1, no accept. After `rst`=0, `in_ready`=1 in the next cycle.
2. Basic operation:
   - Stimulus: a=b=c=d=15, K=5.
   - Required: `busy`=1 for 5 cycles; `out_valid` rises at accept+6 with `out_z`=50625, `out_cycles`=5, `out_timeout`=0.
3. Zero shortcut:
   - Stimulus: a=0, b=200, c=7, d=9.
   - Required: `out_valid`=1 the cycle after accept, `out_z`=0, `out_cycles`=0; `mul_en` never rises.
4. Backpressure:
   - Stimulus: hold `out_ready`=0 for 10 cycles in DONE while driving `in_valid`=1 with new operands.
   - Required: outputs stable, `in_ready`=0, `mul_a`..`mul_d` unchanged. A one-cycle `out_ready` pulse returns to IDLE, and the new tuple is accepted in the next cycle.
5. Timeout:
   - Stimulus A: MAX_CYCLES=16, stub never asserts `ov`.
   - Required A: `out_timeout`=1, `out_cycles`=16, `out_z`=`mul_z` sampled in RUN cycle 16.
   - Stimulus B: K=16 with MAX_CYCLES=16.
   - Required B: `out_timeout`=0, `out_cycles`=16.
6. Mid-run reset:
   - Stimulus: assert `rst` in RUN cycle 3 (K=10).
   - Required: next cycle is IDLE with `mul_en`=0, `mul_rst`=1; `out_valid` stays 0. A following transaction completes with `out_cycles`=10.
